piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter; the counterpart of the team's 8-bit parallel-load register.
- Accepts a WIDTH-bit word on D through a load/ready handshake.
- Shifts the word out one bit per accepted beat on sout.
- The downstream serial consumer paces the stream with enable.
- Feeds the serial link into the receiving shift register. Back-to-back words stream with no gap.

Parameters:
WIDTH, 8, word width in bits (>=2).
MSB_FIRST, 1, 1 = transmit D[WIDTH-1] first; 0 = transmit D[0] first.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
D  input  WIDTH  parallel word to transmit; sampled when load && ready.
load  input  1  upstream request to accept D.
ready  output  1  serializer can accept a word this cycle (combinational from state).
enable  input  1  downstream consumes the current sout bit at this edge.
sout  output  1  current serial bit (registered).
sout_valid  output  1  sout holds a valid bit (registered).
last  output  1  current sout bit is the final bit of the word (combinational).

Behaviour:
- Reset (synchronous, active-high, on the clk edge where reset=1):
  - Clears the shift register, cnt, sout, and sout_valid to 0. State returns to IDLE.
  - reset overrides load and enable in the same cycle.
  - Outputs after reset: sout=0, sout_valid=0, last=0, ready=1.
- State: 2 states, IDLE (sout_valid=0) and SHIFT (sout_valid=1).
  - cnt is a bit counter 0..WIDTH-1, width clog2(WIDTH).
- ready = !sout_valid || (last && enable).
- last = sout_valid && (cnt == WIDTH-1).
- IDLE, load=1 at an edge:
  - Capture D into the shift register.
  - sout <= first bit (D[WIDTH-1] if MSB_FIRST, else D[0]).
  - sout_valid <= 1, cnt <= 0.
  - Latency: the first bit is visible one cycle after the accepting edge.
- IDLE, load=0: hold; sout keeps its last value, sout_valid=0.
- SHIFT, enable=0: stall. sout, cnt, and the shift register all hold, so the bit is stretched. load is ignored because ready=0 unless in the last-bit case below.
- SHIFT, enable=1, cnt<WIDTH-1:
  - Shift one position toward the output end; the vacated bit fills with 0.
  - sout <= next bit, cnt <= cnt+1.
- SHIFT, enable=1, cnt==WIDTH-1:
  - If load=1: reload from D exactly as from IDLE. sout_valid stays 1 with zero idle cycles.
  - Otherwise: sout_valid <= 0, sout <= 0, return to IDLE.
- Each word occupies exactly WIDTH enable-qualified beats. Bit order is fixed at capture.
- Changes on D after capture have no effect.
- load while ready=0 is dropped silently. The upstream must hold load until ready.
- Reset mid-word aborts the word immediately. No partial bits are emitted afterwards.
- enable in IDLE is ignored.

Test Plan:
1. Reset, then release → sout_valid=0, sout=0, ready=1, last=0. Hold 3 cycles with load=0 → no change.
2. Load D=0xAA (MSB_FIRST=1), enable=1 continuously → sout = 1,0,1,0,1,0,1,0 on 8 consecutive cycles starting 1 cycle after load. last=1 only on the 8th bit, then sout_valid=0 and ready=1.
3. Load D=0xCC, deassert enable for 2 cycles on bit index 3 → bit 3 (value 0) held for 3 cycles total with sout_valid=1. The sequence is otherwise 1,1,0,0,1,1,0,0 with 10 valid cycles.
4. Back-to-back: load 0xCC, then assert load with D=0xFF during the cycle where last=1 → 16 contiguous valid bits 11001100_11111111. sout_valid never drops.
5. Mid-word load: while 0xAA is transmitting, pulse load with D=0x00 at bit 2 → ignored (ready=0). 0xAA completes intact.
6. Reset at bit 4 of 0xFF → the next cycle shows sout_valid=0, sout=0, ready=1. A following load of 0x81 transmits 1,0,0,0,0,0,0,1 cleanly; repeat with MSB_FIRST=0, where 0x01 transmits 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word through a load/ready
// handshake and emits it one bit per enable-qualified beat, with gapless reload.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   input  logic             load,
   output logic             ready,
   input  logic             enable,
   output logic             sout,
   output logic             sout_valid,
   output logic             last
);

   localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sout_q, sout_d;
   logic               sout_valid_q, sout_valid_d;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Moves the next bit into the output position; the vacated end fills with 0.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign last       = sout_valid_q && (cnt_q == CNT_LAST);
   assign ready      = !sout_valid_q || (last && enable);
   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;

      // Capture covers both the idle start and the gapless reload on the final beat.
      if (load && ready) begin
         state_d      = ST_SHIFT;
         shreg_d      = D;
         cnt_d        = '0;
         sout_d       = first_bit(D);
         sout_valid_d = 1'b1;
      end else if (state_q == ST_SHIFT && enable) begin
         if (cnt_q == CNT_LAST) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
         end else begin
            shreg_d = shift_word(shreg_q);
            cnt_d   = cnt_q + CNT_ONE;
            sout_d  = first_bit(shift_word(shreg_q));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance.
module tb_piso_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] d_m, d_l;
   logic       load_m, load_l, en_m, en_l;
   logic       ready_m, sout_m, vld_m, last_m;
   logic       ready_l, sout_l, vld_l, last_l;

   int checks;
   int failures;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .D(d_m), .load(load_m), .ready(ready_m),
      .enable(en_m), .sout(sout_m), .sout_valid(vld_m), .last(last_m)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .D(d_l), .load(load_l), .ready(ready_l),
      .enable(en_l), .sout(sout_l), .sout_valid(vld_l), .last(last_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_m = 1'b0; load_l = 1'b0; en_m = 1'b0; en_l = 1'b0;
      d_m = 8'h00; d_l = 8'h00;
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({vld_m, sout_m, ready_m, last_m} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got vld/sout/ready/last=%b expected 0010", i,
                     {vld_m, sout_m, ready_m, last_m});
         end
         tick();
      end
   endtask

   task automatic test_basic_aa();
      logic [7:0] exp;
      exp = 8'b1010_1010;
      d_m = 8'hAA; load_m = 1'b1; en_m = 1'b1;
      tick();
      load_m = 1'b0; d_m = 8'h55;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({vld_m, sout_m, last_m, ready_m} !== {1'b1, exp[7-i], i == 7, i == 7}) begin
            failures++;
            $display("FAIL basic_aa bit=%0d got vld/sout/last/ready=%b expected %b", i,
                     {vld_m, sout_m, last_m, ready_m}, {1'b1, exp[7-i], i == 7, i == 7});
         end
         tick();
      end
      checks++;
      if ({vld_m, sout_m, ready_m, last_m} !== 4'b0010) begin
         failures++;
         $display("FAIL basic_aa_end got vld/sout/ready/last=%b expected 0010",
                  {vld_m, sout_m, ready_m, last_m});
      end
   endtask

   task automatic test_stall();
      logic [9:0] exp_bits;
      logic [9:0] en_pat;
      exp_bits = 10'b11_0000_1100;
      en_pat   = 10'b11_1001_1111;
      d_m = 8'hCC; load_m = 1'b1; en_m = 1'b1;
      tick();
      load_m = 1'b0;
      for (int i = 0; i < 10; i++) begin
         en_m = en_pat[9-i];
         checks++;
         if ({vld_m, sout_m, last_m} !== {1'b1, exp_bits[9-i], i == 9}) begin
            failures++;
            $display("FAIL stall cyc=%0d got vld/sout/last=%b expected %b", i,
                     {vld_m, sout_m, last_m}, {1'b1, exp_bits[9-i], i == 9});
         end
         tick();
      end
      checks++;
      if (vld_m !== 1'b0) begin
         failures++;
         $display("FAIL stall_end got vld=%b expected 0", vld_m);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      exp = 16'b1100_1100_1111_1111;
      d_m = 8'hCC; load_m = 1'b1; en_m = 1'b1;
      tick();
      load_m = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 7) begin
            d_m = 8'hFF; load_m = 1'b1;
            checks++;
            if (ready_m !== 1'b1) begin
               failures++;
               $display("FAIL b2b_ready got %b expected 1", ready_m);
            end
         end else begin
            load_m = 1'b0;
         end
         checks++;
         if ({vld_m, sout_m, last_m} !== {1'b1, exp[15-i], (i == 7) || (i == 15)}) begin
            failures++;
            $display("FAIL b2b bit=%0d got vld/sout/last=%b expected %b", i,
                     {vld_m, sout_m, last_m}, {1'b1, exp[15-i], (i == 7) || (i == 15)});
         end
         tick();
      end
      load_m = 1'b0;
      checks++;
      if (vld_m !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end got vld=%b expected 0", vld_m);
      end
   endtask

   task automatic test_midword_load();
      logic [7:0] exp;
      exp = 8'b1010_1010;
      d_m = 8'hAA; load_m = 1'b1; en_m = 1'b1;
      tick();
      load_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            d_m = 8'h00; load_m = 1'b1;
            checks++;
            if (ready_m !== 1'b0) begin
               failures++;
               $display("FAIL midload_ready got %b expected 0", ready_m);
            end
         end else begin
            load_m = 1'b0;
         end
         checks++;
         if ({vld_m, sout_m} !== {1'b1, exp[7-i]}) begin
            failures++;
            $display("FAIL midload bit=%0d got vld/sout=%b expected %b", i,
                     {vld_m, sout_m}, {1'b1, exp[7-i]});
         end
         tick();
      end
      checks++;
      if (vld_m !== 1'b0) begin
         failures++;
         $display("FAIL midload_end got vld=%b expected 0", vld_m);
      end
   endtask

   task automatic test_reset_midword();
      logic [7:0] exp;
      d_m = 8'hFF; load_m = 1'b1; en_m = 1'b1;
      tick();
      load_m = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({vld_m, sout_m, ready_m, last_m} !== 4'b0010) begin
         failures++;
         $display("FAIL abort got vld/sout/ready/last=%b expected 0010",
                  {vld_m, sout_m, ready_m, last_m});
      end
      exp = 8'b1000_0001;
      d_m = 8'h81; load_m = 1'b1;
      tick();
      load_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({vld_m, sout_m, last_m} !== {1'b1, exp[7-i], i == 7}) begin
            failures++;
            $display("FAIL after_abort bit=%0d got vld/sout/last=%b expected %b", i,
                     {vld_m, sout_m, last_m}, {1'b1, exp[7-i], i == 7});
         end
         tick();
      end
   endtask

   task automatic test_lsb_first();
      logic [15:0] exp;
      // 0x01 then 0xB1 back to back, transmitted bit 0 first.
      exp = 16'b1000_0000_1000_1101;
      d_l = 8'h01; load_l = 1'b1; en_l = 1'b1;
      tick();
      load_l = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 7) begin
            d_l = 8'hB1; load_l = 1'b1;
         end else begin
            load_l = 1'b0;
         end
         checks++;
         if ({vld_l, sout_l, last_l} !== {1'b1, exp[15-i], (i == 7) || (i == 15)}) begin
            failures++;
            $display("FAIL lsb bit=%0d got vld/sout/last=%b expected %b", i,
                     {vld_l, sout_l, last_l}, {1'b1, exp[15-i], (i == 7) || (i == 15)});
         end
         tick();
      end
      load_l = 1'b0;
      checks++;
      if ({vld_l, sout_l, ready_l} !== 3'b001) begin
         failures++;
         $display("FAIL lsb_end got vld/sout/ready=%b expected 001", {vld_l, sout_l, ready_l});
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_aa();
      test_stall();
      test_back_to_back();
      test_midword_load();
      test_reset_midword();
      test_lsb_first();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
